mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single byte-wide memory port between two requesters. Requester 0 is the multicycle CPU controller (instruction fetch bytes, LB, SB). Requester 1 is the debug/program loader.
- Sits between the controller/datapath memory interface and the memory model/RAM.
- Fixed-latency memory access with a req/ack handshake and round-robin arbitration.
- The CPU stalls its FSM until it receives ack0.

Parameters:
- WIDTH, 8, data width of the memory port.
- ADDR_W, 8, address width.
- RD_LAT, 2, cycles the memory needs with mem_read held before mem_rd is valid; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req0  in  1  CPU access request; held until ack0.
- we0  in  1  CPU write enable (1 = write, 0 = read).
- adr0  in  ADDR_W  CPU address.
- wd0  in  WIDTH  CPU write data.
- ack0  out  1  one-cycle completion pulse to the CPU.
- req1/we1/adr1/wd1/ack1: same set for the loader.
- rdata  out  WIDTH  read data; valid in the ack cycle, held until the next ack.
- busy  out  1  high while not in IDLE.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_adr  out  ADDR_W  memory address.
- mem_wd  out  WIDTH  memory write data.
- mem_rd  in  WIDTH  memory read data.

Behaviour:
- Reset: state=IDLE; all outputs 0 (ack0, ack1, rdata, busy, mem_read, mem_write, mem_adr, mem_wd); last_grant=1, so requester 0 wins the first tie; cnt=0.
- Reset mid-access: the access is abandoned, no ack is issued, strobes are 0 from the cycle after the reset edge.
- IDLE:
  - If any req is high, select a winner.
  - Latch we/adr/wd of the winner into mem_adr/mem_wd; load cnt with RD_LAT-1 for reads, 0 for writes.
  - Record the winner as gnt, go to ACCESS.
  - No request: stay in IDLE.
- Arbitration (round-robin):
  - Only one req high: that requester wins.
  - Both high: the requester that is not last_grant wins.
  - last_grant updates at entry to ACCESS.
- ACCESS:
  - Read: mem_read=1 every ACCESS cycle, mem_adr stable. When cnt==0, capture mem_rd into rdata and go to ACK; otherwise cnt decrements.
  - Write: mem_write=1 for exactly one cycle, then go to ACK. rdata is unchanged.
- ACK: ack<gnt>=1 for one cycle, strobes 0, then go to IDLE.
- Timing, request first seen high in IDLE at cycle 0:
  - Read: mem_read in cycles 1..RD_LAT, ack in cycle RD_LAT+1, IDLE in cycle RD_LAT+2.
  - Write: mem_write in cycle 1, ack in cycle 2.
- Requester rules:
  - A requester must drop req in the cycle after its ack unless it wants another access.
  - req still high in the IDLE cycle after ack is treated as a new request.
- req dropped mid-access: the access still completes and ack still pulses. Inputs are latched, so adr/wd changes during ACCESS are ignored.
- Never both ack0 and ack1 in the same cycle. Never mem_read and mem_write together.
- busy=1 in ACCESS and ACK.
- Worst-case wait for a requester: one foreign access (RD_LAT+2 cycles) plus its own.

Optional Feature:
- Macro: ARB_LOCK_EN.
- Defined:
  - Adds inputs lock0 and lock1 (1 bit each).
  - If the requester granted last has its lock high and its req high in IDLE, it wins regardless of the other req, and last_grant is not updated.
  - If its req is low, normal round-robin applies, so an idle lock cannot deadlock.
  - Lets the CPU keep the port across the four FETCH byte reads.
- Undefined: the lock ports do not exist; pure round-robin.

Test Plan:
- RD_LAT=2, reset, req0=1 we0=0 adr0=8'h10 with memory[10]=8'hA5 → mem_read cycles 1-2 with mem_adr=8'h10; ack0 and rdata=8'hA5 in cycle 3; busy low in cycle 4.
- req1=1 we1=1 adr1=8'h20 wd1=8'h3C → mem_write high only in cycle 1 with mem_adr=8'h20 and mem_wd=8'h3C; ack1 in cycle 2; rdata unchanged.
- req0 and req1 both high continuously → grant order 0,1,0,1 (first tie goes to 0); acks alternate every 4 cycles; never two acks in one cycle.
- rst asserted in the second ACCESS cycle of a read → no ack; strobes 0 in the next cycle; a subsequent req1 is granted first-tie-to-0 rules from reset state.
- req0 dropped after cycle 1 of a read → ack0 still pulses in cycle 3; arbiter returns to IDLE.
- ARB_LOCK_EN defined, lock0=1 with both req held for 4 accesses → four consecutive ack0 before any ack1; after lock0 falls, the next tie grants requester 1.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// mem_port_arbiter_if : requester and memory-side signal bundle for the
//                       two-requester byte-wide memory port arbiter.
// Optional macro      : ARB_LOCK_EN (adds lock0/lock1)
// Revision            : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 8
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] adr0;
  logic [WIDTH-1:0]  wd0;
  logic              ack0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] adr1;
  logic [WIDTH-1:0]  wd1;
  logic              ack1;

  logic [WIDTH-1:0]  rdata;
  logic              busy;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_adr;
  logic [WIDTH-1:0]  mem_wd;
  logic [WIDTH-1:0]  mem_rd;

`ifdef ARB_LOCK_EN
  logic              lock0;
  logic              lock1;

  modport slave (
    input  req0, we0, adr0, wd0, lock0,
    input  req1, we1, adr1, wd1, lock1,
    input  mem_rd,
    output ack0, ack1, rdata, busy,
    output mem_read, mem_write, mem_adr, mem_wd
  );

  modport master (
    output req0, we0, adr0, wd0, lock0,
    output req1, we1, adr1, wd1, lock1,
    output mem_rd,
    input  ack0, ack1, rdata, busy,
    input  mem_read, mem_write, mem_adr, mem_wd
  );
`else
  modport slave (
    input  req0, we0, adr0, wd0,
    input  req1, we1, adr1, wd1,
    input  mem_rd,
    output ack0, ack1, rdata, busy,
    output mem_read, mem_write, mem_adr, mem_wd
  );

  modport master (
    output req0, we0, adr0, wd0,
    output req1, we1, adr1, wd1,
    output mem_rd,
    input  ack0, ack1, rdata, busy,
    input  mem_read, mem_write, mem_adr, mem_wd
  );
`endif

endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter : round-robin arbiter sharing one fixed-latency byte-wide
//                    memory port between the CPU (0) and the loader (1).
// Optional macro   : ARB_LOCK_EN (last grantee may hold the port via lockN)
// Revision         : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 2
) (
  input  wire logic            clk,
  input  wire logic            rst,
  mem_port_arbiter_if.slave    bus
);

  generate
    if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_rd_lat
      $error("mem_port_arbiter: RD_LAT must be within 1..15");
    end
  endgenerate

  localparam logic [3:0] RD_CNT_INIT = 4'(RD_LAT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nx;

  logic              gnt;
  logic              last_grant;
  logic              we_l;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] adr_l;
  logic [WIDTH-1:0]  wd_l;
  logic [WIDTH-1:0]  rdata_q;

  logic              any_req;
  logic              win;
  logic              upd_last;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_adr;
  logic [WIDTH-1:0]  sel_wd;

  assign any_req = bus.req0 | bus.req1;

  // Arbitration: a tie goes to whoever was not granted last.
  always_comb begin
    win      = 1'b0;
    upd_last = 1'b1;
    if (bus.req0 && bus.req1) begin
      win = ~last_grant;
    end else begin
      win = bus.req1;
    end
`ifdef ARB_LOCK_EN
    // Locked holder keeps the port only while it is actually requesting.
    if (last_grant ? (bus.lock1 && bus.req1) : (bus.lock0 && bus.req0)) begin
      win      = last_grant;
      upd_last = 1'b0;
    end
`endif
  end

  always_comb begin
    sel_we  = bus.we0;
    sel_adr = bus.adr0;
    sel_wd  = bus.wd0;
    if (win) begin
      sel_we  = bus.we1;
      sel_adr = bus.adr1;
      sel_wd  = bus.wd1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = ACCESS;
      ACCESS:  if (we_l || cnt == 4'd0) state_nx = ACK;
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt        <= 1'b0;
      last_grant <= 1'b1;
      we_l       <= 1'b0;
      cnt        <= 4'd0;
      adr_l      <= '0;
      wd_l       <= '0;
      rdata_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt   <= win;
            we_l  <= sel_we;
            adr_l <= sel_adr;
            wd_l  <= sel_wd;
            cnt   <= sel_we ? 4'd0 : RD_CNT_INIT;
            if (upd_last) begin
              last_grant <= win;
            end
          end
        end
        ACCESS: begin
          if (!we_l) begin
            if (cnt == 4'd0) begin
              rdata_q <= bus.mem_rd;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.mem_read  = (state == ACCESS) && !we_l;
  assign bus.mem_write = (state == ACCESS) &&  we_l;
  assign bus.mem_adr   = adr_l;
  assign bus.mem_wd    = wd_l;
  assign bus.ack0      = (state == ACK) && !gnt;
  assign bus.ack1      = (state == ACK) &&  gnt;
  assign bus.busy      = (state != IDLE);
  assign bus.rdata     = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter : directed self-checking bench for mem_port_arbiter
//                       (RD_LAT=2); lock scenario built only with ARB_LOCK_EN.
// Revision            : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [7:0] mem [256];

  mem_port_arbiter_if #(.WIDTH(8), .ADDR_W(8)) bus ();

  mem_port_arbiter #(.WIDTH(8), .ADDR_W(8), .RD_LAT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_rd = mem[bus.mem_adr];

  always @(posedge clk) begin
    if (bus.mem_write) mem[bus.mem_adr] <= bus.mem_wd;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  initial begin
    int exp_g;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'hA5;
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.adr0 = 8'h00; bus.wd0 = 8'h00;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.adr1 = 8'h00; bus.wd1 = 8'h00;
`ifdef ARB_LOCK_EN
    bus.lock0 = 1'b0; bus.lock1 = 1'b0;
`endif

    // Reset state
    tick(); tick();
    chk("rst_ack0", 32'(bus.ack0), 0);
    chk("rst_ack1", 32'(bus.ack1), 0);
    chk("rst_rdata", 32'(bus.rdata), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_mem_read", 32'(bus.mem_read), 0);
    chk("rst_mem_write", 32'(bus.mem_write), 0);
    chk("rst_mem_adr", 32'(bus.mem_adr), 0);
    chk("rst_mem_wd", 32'(bus.mem_wd), 0);
    rst = 1'b0;
    tick();

    // CPU read of 0x10, address changed mid-access must be ignored
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.adr0 = 8'h10;
    tick();
    chk("rd_c1_mem_read", 32'(bus.mem_read), 1);
    chk("rd_c1_mem_write", 32'(bus.mem_write), 0);
    chk("rd_c1_adr", 32'(bus.mem_adr), 32'h10);
    chk("rd_c1_busy", 32'(bus.busy), 1);
    chk("rd_c1_ack0", 32'(bus.ack0), 0);
    bus.adr0 = 8'h55;
    tick();
    chk("rd_c2_mem_read", 32'(bus.mem_read), 1);
    chk("rd_c2_adr", 32'(bus.mem_adr), 32'h10);
    chk("rd_c2_ack0", 32'(bus.ack0), 0);
    tick();
    chk("rd_c3_ack0", 32'(bus.ack0), 1);
    chk("rd_c3_ack1", 32'(bus.ack1), 0);
    chk("rd_c3_rdata", 32'(bus.rdata), 32'hA5);
    chk("rd_c3_mem_read", 32'(bus.mem_read), 0);
    bus.req0 = 1'b0;
    tick();
    chk("rd_c4_busy", 32'(bus.busy), 0);
    chk("rd_c4_ack0", 32'(bus.ack0), 0);

    // Loader write of 0x3C to 0x20
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.adr1 = 8'h20; bus.wd1 = 8'h3C;
    tick();
    chk("wr_c1_mem_write", 32'(bus.mem_write), 1);
    chk("wr_c1_mem_read", 32'(bus.mem_read), 0);
    chk("wr_c1_adr", 32'(bus.mem_adr), 32'h20);
    chk("wr_c1_wd", 32'(bus.mem_wd), 32'h3C);
    tick();
    chk("wr_c2_ack1", 32'(bus.ack1), 1);
    chk("wr_c2_ack0", 32'(bus.ack0), 0);
    chk("wr_c2_mem_write", 32'(bus.mem_write), 0);
    chk("wr_c2_rdata", 32'(bus.rdata), 32'hA5);
    bus.req1 = 1'b0; bus.we1 = 1'b0;
    tick();
    chk("wr_c3_busy", 32'(bus.busy), 0);
    chk("wr_mem_content", 32'(mem[8'h20]), 32'h3C);

    // Both requesting reads: grants 0,1,0,1 with an ack every 4 cycles
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.adr0 = 8'h10;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.adr1 = 8'h20;
    exp_g = 0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      chk("rr_no_double_ack", 32'(bus.ack0 & bus.ack1), 0);
      chk("rr_no_rd_wr", 32'(bus.mem_read & bus.mem_write), 0);
      if (k % 4 == 3) begin
        chk("rr_ack0", 32'(bus.ack0), (exp_g == 0) ? 1 : 0);
        chk("rr_ack1", 32'(bus.ack1), (exp_g == 1) ? 1 : 0);
        chk("rr_rdata", 32'(bus.rdata), (exp_g == 0) ? 32'hA5 : 32'h3C);
        exp_g = 1 - exp_g;
      end else begin
        chk("rr_no_ack", 32'(bus.ack0 | bus.ack1), 0);
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    tick();
    chk("rr_end_busy", 32'(bus.busy), 0);

    // Reset during the second ACCESS cycle of a read
    bus.req0 = 1'b1; bus.adr0 = 8'h10;
    tick();
    tick();
    chk("rstmid_c2_mem_read", 32'(bus.mem_read), 1);
    rst = 1'b1;
    tick();
    chk("rstmid_mem_read", 32'(bus.mem_read), 0);
    chk("rstmid_ack0", 32'(bus.ack0), 0);
    chk("rstmid_busy", 32'(bus.busy), 0);
    chk("rstmid_rdata", 32'(bus.rdata), 0);
    rst = 1'b0;
    bus.req0 = 1'b0;
    tick();
    chk("rstmid_no_late_ack", 32'(bus.ack0 | bus.ack1), 0);
    // First tie after reset goes to requester 0 again
    bus.req0 = 1'b1; bus.adr0 = 8'h10;
    bus.req1 = 1'b1; bus.adr1 = 8'h20;
    tick(); tick(); tick();
    chk("rstmid_tie_ack0", 32'(bus.ack0), 1);
    chk("rstmid_tie_ack1", 32'(bus.ack1), 0);
    bus.req0 = 1'b0;
    tick(); tick(); tick(); tick();
    chk("rstmid_then_ack1", 32'(bus.ack1), 1);
    chk("rstmid_then_rdata", 32'(bus.rdata), 32'h3C);
    bus.req1 = 1'b0;
    tick();
    chk("rstmid_end_busy", 32'(bus.busy), 0);

    // req0 dropped after cycle 1: access still completes
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.adr0 = 8'h20;
    tick();
    bus.req0 = 1'b0;
    tick();
    chk("drop_c2_mem_read", 32'(bus.mem_read), 1);
    tick();
    chk("drop_c3_ack0", 32'(bus.ack0), 1);
    chk("drop_c3_rdata", 32'(bus.rdata), 32'h3C);
    tick();
    chk("drop_c4_busy", 32'(bus.busy), 0);
    chk("drop_c4_ack0", 32'(bus.ack0), 0);

`ifdef ARB_LOCK_EN
    // lock0 holds the port for four reads, then a tie goes to requester 1
    bus.lock0 = 1'b1;
    bus.req0 = 1'b1; bus.adr0 = 8'h10;
    bus.req1 = 1'b1; bus.adr1 = 8'h20;
    for (int k = 1; k <= 15; k++) begin
      tick();
      chk("lock_no_ack1", 32'(bus.ack1), 0);
      if (k % 4 == 3) chk("lock_ack0", 32'(bus.ack0), 1);
    end
    bus.lock0 = 1'b0;
    tick(); tick(); tick(); tick();
    chk("unlock_ack1", 32'(bus.ack1), 1);
    chk("unlock_ack0", 32'(bus.ack0), 0);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    tick();
    chk("unlock_end_busy", 32'(bus.busy), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
